dedup_job_scheduler: RTL

- Shares one sort/unique-element engine between NUM_REQ requesters.
- For each job: picks a requester by round-robin, drives the engine's load pulse and then its start pulse, waits for the engine's done, and returns the unique-element count to the granted requester with a one-cycle ack.
- Sits between the client blocks and the single engine instance. It is the only driver of the engine's Ld/En inputs.

---
 rtl/dedup_job_scheduler_pkg.sv | 16 +
 rtl/dedup_job_scheduler_rr_arbiter.sv | 33 +++
 rtl/dedup_job_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dedup_job_scheduler_pkg.sv
// Shared state encoding and default sizing for the deduplication job scheduler.
package dedup_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        RESP
    } sched_state_e;

    localparam int NUM_REQ_DEF = 4;
    localparam int CNT_W_DEF   = 32;
    localparam int TIMEOUT_DEF = 4096;

endpackage

// File: rtl/dedup_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr, wrapping to 0.
module rr_arbiter
    import dedup_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic                       valid,
    output logic [NUM_REQ-1:0]         gnt_oh,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int pos;

    always_comb begin
        valid  = 1'b0;
        gnt_oh = '0;
        idx    = '0;
        pos    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = (int'(rr_ptr) + i) % NUM_REQ;
            if (!valid && req[pos]) begin
                valid       = 1'b1;
                gnt_oh[pos] = 1'b1;
                idx         = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/dedup_job_scheduler.sv
// Shares one sort/unique engine between NUM_REQ requesters, one job at a time.
// Define DEDUP_SCHED_TIMEOUT_EN to enable the WAIT-state watchdog.
module dedup_job_scheduler
    import dedup_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] ack,
    output logic [CNT_W-1:0]   result_count,
    output logic               result_err,
    output logic               busy,
    output logic               eng_ld,
    output logic               eng_en,
    input  logic               eng_done,
    input  logic [CNT_W-1:0]   eng_count
);

    // state | meaning
    // IDLE  | no job; arbitrate over req, grant and pulse eng_ld on a winner
    // LOAD  | eng_ld high for this cycle; raise eng_en next
    // START | eng_en high for this cycle; enter WAIT with timer cleared
    // WAIT  | engine running; exit on eng_done (or watchdog expiry)
    // RESP  | ack pulse to owner; release grant and rotate priority

    localparam int IDX_W = $clog2(NUM_REQ);

    sched_state_e       state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [CNT_W-1:0]   result_count_q, result_count_d;
    logic               eng_ld_q, eng_ld_d;
    logic               eng_en_q, eng_en_d;
    logic               busy_q, busy_d;

    logic               arb_valid;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;

`ifdef DEDUP_SCHED_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT) + 1;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             result_err_q, result_err_d;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (arb_valid),
        .gnt_oh (arb_gnt),
        .idx    (arb_idx)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        rr_ptr_d       = rr_ptr_q;
        gnt_d          = gnt_q;
        ack_d          = ack_q;
        result_count_d = result_count_q;
        eng_ld_d       = eng_ld_q;
        eng_en_d       = eng_en_q;
`ifdef DEDUP_SCHED_TIMEOUT_EN
        timer_d        = timer_q;
        result_err_d   = result_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    idx_d    = arb_idx;
                    gnt_d    = arb_gnt;
                    eng_ld_d = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                eng_ld_d = 1'b0;
                eng_en_d = 1'b1;
                state_d  = START;
            end
            START: begin
                eng_en_d = 1'b0;
`ifdef DEDUP_SCHED_TIMEOUT_EN
                timer_d  = '0;
`endif
                state_d  = WAIT;
            end
            WAIT: begin
                // gnt_q already holds onehot(idx), so it doubles as the ack vector
                if (eng_done) begin
                    result_count_d = eng_count;
                    ack_d          = gnt_q;
                    state_d        = RESP;
`ifdef DEDUP_SCHED_TIMEOUT_EN
                    result_err_d   = 1'b0;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    result_count_d = '0;
                    result_err_d   = 1'b1;
                    ack_d          = gnt_q;
                    state_d        = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
`endif
                end
            end
            RESP: begin
                ack_d    = '0;
                gnt_d    = '0;
                rr_ptr_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                state_d  = IDLE;
`ifdef DEDUP_SCHED_TIMEOUT_EN
                result_err_d = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            rr_ptr_q       <= '0;
            gnt_q          <= '0;
            ack_q          <= '0;
            result_count_q <= '0;
            eng_ld_q       <= 1'b0;
            eng_en_q       <= 1'b0;
            busy_q         <= 1'b0;
`ifdef DEDUP_SCHED_TIMEOUT_EN
            timer_q        <= '0;
            result_err_q   <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            rr_ptr_q       <= rr_ptr_d;
            gnt_q          <= gnt_d;
            ack_q          <= ack_d;
            result_count_q <= result_count_d;
            eng_ld_q       <= eng_ld_d;
            eng_en_q       <= eng_en_d;
            busy_q         <= busy_d;
`ifdef DEDUP_SCHED_TIMEOUT_EN
            timer_q        <= timer_d;
            result_err_q   <= result_err_d;
`endif
        end
    end

    assign gnt          = gnt_q;
    assign ack          = ack_q;
    assign result_count = result_count_q;
    assign eng_ld       = eng_ld_q;
    assign eng_en       = eng_en_q;
    assign busy         = busy_q;
`ifdef DEDUP_SCHED_TIMEOUT_EN
    assign result_err   = result_err_q;
`else
    assign result_err   = 1'b0;
`endif

endmodule
